// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared master encodings, default widths and counter sizing helper
package mem_port_arbiter_pkg;
    typedef enum logic {MST_M0 = 1'b0, MST_M1 = 1'b1} mst_e;
    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int BURST_MAX_DEF = 4;
    function automatic int cnt_w(input int burst);
        return $clog2(burst + 1);
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester bus (req/we/addr/wdata -> gnt/rvalid/rdata) and RAM-side bus (en/we/addr/wdata -> rdata)
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface mem_port_arbiter_mem_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/mem_port_arbiter_arb2_rr.sv
// mem_port_arbiter_arb2_rr: two-way burst-bounded round-robin arbiter; ports clk, rst, i_req[1:0] -> o_gnt[1:0] one-hot
module mem_port_arbiter_arb2_rr
    import mem_port_arbiter_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    localparam int CW = cnt_w(BURST_MAX);
    mst_e          r_owner;
    logic [CW-1:0] r_cnt;
    logic          w_sat;
    logic          w_any;
    mst_e          w_win;
    assign w_sat = r_cnt >= CW'(BURST_MAX);
    assign w_any = |i_req & !rst;
    // Under contention the owner keeps the port until its streak saturates, then the other side wins.
    assign w_win = (&i_req) ? mst_e'(r_owner ^ w_sat) : mst_e'(i_req[1]);
    assign o_gnt = {w_any & (w_win == MST_M1), w_any & (w_win == MST_M0)};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= MST_M0;
            r_cnt   <= '0;
        end else if (!w_any) begin
            r_cnt <= '0;
        end else if (w_win == r_owner) begin
            r_cnt <= w_sat ? r_cnt : r_cnt + 1'b1;
        end else begin
            r_owner <= w_win;
            r_cnt   <= CW'(1);
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync RAM between M0/M1; ports clk, rst, m0/m1 requester buses (slave), mem RAM bus (master)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     m0,
    mem_port_arbiter_if.slave     m1,
    mem_port_arbiter_mem_if.master mem
);
    logic [1:0]        w_gnt;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              r_rd_pend;
    mst_e              r_rd_tag;
    mem_port_arbiter_arb2_rr #(.BURST_MAX(BURST_MAX)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req ({m1.req, m0.req}),
        .o_gnt (w_gnt)
    );
    // M0 is selected whenever M1 is not granted, so the RAM bus is stable when idle.
    assign w_sel_we  = w_gnt[1] ? m1.we    : m0.we;
    assign w_addr    = w_gnt[1] ? m1.addr  : m0.addr;
    assign w_wdata   = w_gnt[1] ? m1.wdata : m0.wdata;
    assign m0.gnt    = w_gnt[0];
    assign m1.gnt    = w_gnt[1];
    assign mem.en    = |w_gnt;
    assign mem.we    = w_sel_we & mem.en;
    assign mem.addr  = w_addr;
    assign mem.wdata = w_wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= MST_M0;
        end else begin
            r_rd_pend <= mem.en & !w_sel_we;
            r_rd_tag  <= w_gnt[1] ? MST_M1 : MST_M0;
        end
    end
    // RAM data is not buffered; the rvalid is masked while rst is high so a read issued just before reset is dropped.
    assign m0.rvalid = r_rd_pend & !rst & (r_rd_tag == MST_M0);
    assign m1.rvalid = r_rd_pend & !rst & (r_rd_tag == MST_M1);
    assign m0.rdata  = mem.rdata;
    assign m1.rdata  = mem.rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (BURST_MAX 4 and 1) driven in lockstep, checked against a behavioural model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        r0, w0, r1, w1;
    logic [31:0] a0, d0, a1, d1;
    int          total = 0;
    int          bad = 0;
    always #5 clk = ~clk;

    mem_port_arbiter_if     m0a(), m1a(), m0b(), m1b();
    mem_port_arbiter_mem_if mema(), memb();
    assign {m0a.req, m0a.we, m0a.addr, m0a.wdata} = {r0, w0, a0, d0};
    assign {m0b.req, m0b.we, m0b.addr, m0b.wdata} = {r0, w0, a0, d0};
    assign {m1a.req, m1a.we, m1a.addr, m1a.wdata} = {r1, w1, a1, d1};
    assign {m1b.req, m1b.we, m1b.addr, m1b.wdata} = {r1, w1, a1, d1};

    mem_port_arbiter #(.BURST_MAX(4)) dut_a (.clk(clk), .rst(rst), .m0(m0a), .m1(m1a), .mem(mema));
    mem_port_arbiter #(.BURST_MAX(1)) dut_b (.clk(clk), .rst(rst), .m0(m0b), .m1(m1b), .mem(memb));

    logic [31:0] rama [16];
    logic [31:0] ramb [16];
    logic [31:0] rda, rdb;
    assign mema.rdata = rda;
    assign memb.rdata = rdb;
    always @(posedge clk) begin
        if (mema.en) begin
            if (mema.we) rama[mema.addr[3:0]] = mema.wdata;
            else rda <= rama[mema.addr[3:0]];
        end
        if (memb.en) begin
            if (memb.we) ramb[memb.addr[3:0]] = memb.wdata;
            else rdb <= ramb[memb.addr[3:0]];
        end
    end

    int          burst [2] = '{4, 1};
    bit          own [2];
    int          cnt [2];
    bit          pend [2];
    bit          tag [2];
    logic [31:0] pdat [2];
    logic [31:0] ref_mem [2][16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            rama[i] = 32'hA000 + i;
            ramb[i] = 32'hA000 + i;
            ref_mem[0][i] = 32'hA000 + i;
            ref_mem[1][i] = 32'hA000 + i;
        end
        rama[5] = 32'hDEAD;
        ramb[5] = 32'hDEAD;
        ref_mem[0][5] = 32'hDEAD;
        ref_mem[1][5] = 32'hDEAD;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a read returns one cycle later; with contention the current owner keeps the port
    // for at most burst[k] consecutive grants before the waiting master gets it.
    task automatic cmp(input int k, input logic g0, g1, en, we, input logic [31:0] ad, wd,
                       input logic v0, v1, input logic [31:0] rd0, rd1);
        string p = (k == 0) ? "a" : "b";
        bit any, win, ew;
        logic [31:0] ea;
        if (rst) begin
            chk({p, "_rst_gnt"}, {30'd0, g1, g0}, 0);
            chk({p, "_rst_en"}, {30'd0, en, we}, 0);
            chk({p, "_rst_rv"}, {30'd0, v1, v0}, 0);
            own[k] = 0;
            cnt[k] = 0;
            pend[k] = 0;
        end else begin
            any = r0 | r1;
            win = (r0 & r1) ? ((cnt[k] < burst[k]) ? own[k] : !own[k]) : r1;
            ew = win ? w1 : w0;
            ea = win ? a1 : a0;
            chk({p, "_gnt"}, {30'd0, g1, g0}, any ? (win ? 2 : 1) : 0);
            chk({p, "_en"}, {31'd0, en}, {31'd0, any});
            chk({p, "_we"}, {31'd0, we}, {31'd0, any & ew});
            chk({p, "_addr"}, ad, ea);
            if (any & ew) chk({p, "_wdata"}, wd, win ? d1 : d0);
            chk({p, "_rv"}, {30'd0, v1, v0}, pend[k] ? (tag[k] ? 2 : 1) : 0);
            if (pend[k]) chk({p, "_rdata"}, tag[k] ? rd1 : rd0, pdat[k]);
            if (any) begin
                if (win == own[k]) cnt[k] = (cnt[k] < burst[k]) ? cnt[k] + 1 : cnt[k];
                else begin
                    own[k] = win;
                    cnt[k] = 1;
                end
                pend[k] = !ew;
                tag[k] = win;
                pdat[k] = ref_mem[k][ea[3:0]];
                if (ew) ref_mem[k][ea[3:0]] = win ? d1 : d0;
            end else begin
                cnt[k] = 0;
                pend[k] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        cmp(0, m0a.gnt, m1a.gnt, mema.en, mema.we, mema.addr, mema.wdata, m0a.rvalid, m1a.rvalid, m0a.rdata, m1a.rdata);
        cmp(1, m0b.gnt, m1b.gnt, memb.en, memb.we, memb.addr, memb.wdata, m0b.rvalid, m1b.rvalid, m0b.rdata, m1b.rdata);
    end

    task automatic step(input logic rr, q0, e0, input logic [31:0] x0, y0,
                        input logic q1, e1, input logic [31:0] x1, y1);
        @(posedge clk);
        #1;
        rst = rr;
        {r0, w0, a0, d0} = {q0, e0, x0, y0};
        {r1, w1, a1, d1} = {q1, e1, x1, y1};
        @(negedge clk);
    endtask

    logic [8:0] sa, sb;

    initial begin
        rst = 1'b1;
        {r0, w0, a0, d0} = '0;
        {r1, w1, a1, d1} = '0;
        step(1, 1, 0, 0, 0, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 1, 0, 1, 0);
        chk("rst_both_req", {26'd0, m1a.gnt, m0a.gnt, m1b.gnt, m0b.gnt, mema.en, memb.en}, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, i, 0, 1, 0, i + 4, 0);
            if (i == 0) chk("release_gnt0", {28'd0, m1a.gnt, m0a.gnt, m1b.gnt, m0b.gnt}, 4'b0101);
            sa[i] = m1a.gnt;
            sb[i] = m1b.gnt;
        end
        chk("pattern_b4", {23'd0, sa}, 9'h0F0);
        chk("pattern_b1", {23'd0, sb}, 9'h0AA);

        step(0, 1, 0, 5, 0, 0, 0, 0, 0);
        chk("rd5_gnt", {30'd0, m1a.gnt, m0a.gnt}, 2'b01);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd5_rv", {30'd0, m1a.rvalid, m0a.rvalid}, 2'b01);
        chk("rd5_data", m0a.rdata, 32'hDEAD);

        step(0, 0, 0, 0, 0, 1, 1, 7, 32'h1234);
        chk("wr7_we", {29'd0, m1a.gnt, mema.en, mema.we}, 3'b111);
        step(0, 1, 0, 7, 0, 0, 0, 0, 0);
        chk("rd7_we", {30'd0, m0a.gnt, mema.we}, 2'b10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd7_data", {m0a.rvalid ? m0a.rdata : 32'hX}, 32'h1234);

        step(0, 1, 0, 5, 0, 0, 0, 0, 0);
        chk("prerst_gnt", {31'd0, m0a.gnt}, 1);
        step(1, 1, 0, 0, 0, 1, 0, 1, 0);
        chk("rst_drop_rv", {30'd0, m0a.rvalid, m0b.rvalid}, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 2, 0, 1, 0, 3, 0);
            chk($sformatf("postrst_a%0d", i), {30'd0, m1a.gnt, m0a.gnt}, (i < 4) ? 2'b01 : 2'b10);
        end

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 0, 2, 0);
        chk("alt_g1", {30'd0, m1b.gnt, m0b.gnt}, 2'b01);
        step(0, 1, 0, 3, 0, 1, 0, 2, 0);
        chk("alt_g2", {30'd0, m1b.gnt, m0b.gnt}, 2'b10);
        chk("alt_rv1", {30'd0, m1b.rvalid, m0b.rvalid}, 2'b01);
        chk("alt_d1", m0b.rdata, 32'hA001);
        step(0, 1, 0, 3, 0, 0, 0, 2, 0);
        chk("alt_g3", {30'd0, m1b.gnt, m0b.gnt}, 2'b01);
        chk("alt_rv2", {30'd0, m1b.rvalid, m0b.rvalid}, 2'b10);
        chk("alt_d2", m1b.rdata, 32'hA002);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("alt_rv3", {30'd0, m1b.rvalid, m0b.rvalid}, 2'b01);
        chk("alt_d3", m0b.rdata, 32'hA003);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
